// File: rtl/float32_to_fltn_cplx_pipe.sv
// float32_to_fltn_cplx_pipe: 3-stage multi-lane complex float32 to reduced-float converter; FLT_RNE_EN selects round-to-nearest-even, else truncation
module float32_to_fltn_cplx_pipe #(
  parameter int NUM_LANES = 1,
  parameter int OUT_EXP_W = 8,
  parameter int OUT_MAN_W = 9
)(
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      s_valid,
  output logic                                      s_ready,
  input  logic [NUM_LANES*64-1:0]                   s_data,
  output logic                                      m_valid,
  input  logic                                      m_ready,
  output logic [NUM_LANES*2*(1+OUT_EXP_W+OUT_MAN_W)-1:0] m_data,
  output logic [NUM_LANES*2-1:0]                    m_ovf,
  output logic [NUM_LANES*2-1:0]                    m_unf
);
  localparam int W = 2*NUM_LANES;
  localparam int OW = 1+OUT_EXP_W+OUT_MAN_W;
  localparam int D = 23-OUT_MAN_W;
  localparam int OB = (1<<(OUT_EXP_W-1))-1;
  localparam int EMAX = (1<<OUT_EXP_W)-1;
  localparam logic [OUT_MAN_W-1:0] QM = OUT_MAN_W'(1) << (OUT_MAN_W-1);
`ifdef FLT_RNE_EN
  localparam int KW = 23;
`else
  localparam int KW = OUT_MAN_W;
`endif
  logic adv, v1, v2;
  assign adv = ~m_valid | m_ready;
  assign s_ready = adv;
  // stage valid chain, frozen as a whole when the output is stalled
  always_ff @(posedge clk)
    if (rst) {v1, v2, m_valid} <= '0;
    else if (adv) {v1, v2, m_valid} <= {s_valid, v1, v2};
  for (genvar w = 0; w < W; w++) begin : g_w
    logic [31:0] x;
    logic s1_s, s1_u, s2_s, s2_u, ov, un, inc, ovf, unf;
    logic [1:0] s1_c, s2_c;
    logic signed [9:0] s1_e, s2_e;
    logic [KW-1:0] s1_m;
    logic [OUT_MAN_W-1:0] s2_m;
    logic [OUT_MAN_W:0] sum;
    logic [OW-1:0] pk, od;
    assign x = s_data[32*w +: 32];
    // S1: classify (0 normal, 1 zero/denormal, 2 inf, 3 nan) and rebias exponent
    always_ff @(posedge clk)
      if (rst) {s1_s, s1_c, s1_u, s1_e, s1_m} <= '0;
      else if (adv) begin
        s1_s <= x[31];
        s1_c <= x[30:23] == 8'hFF ? (x[22:0] != '0 ? 2'd3 : 2'd2) : x[30:23] == 8'h00 ? 2'd1 : 2'd0;
        s1_u <= x[30:23] == 8'h00 && x[22:0] != '0;
        s1_e <= 10'(x[30:23]) - 10'd127 + 10'(OB);
        s1_m <= x[22 -: KW];
      end
`ifdef FLT_RNE_EN
    assign inc = s1_m[D-1] && ((s1_m & ((23'd1 << (D-1)) - 23'd1)) != '0 || s1_m[D]);
`else
    assign inc = 1'b0;
`endif
    assign sum = {1'b0, s1_m[KW-1 -: OUT_MAN_W]} + (OUT_MAN_W+1)'(inc);
    // S2: apply rounding; a mantissa carry bumps the exponent and leaves m at zero
    always_ff @(posedge clk)
      if (rst) {s2_s, s2_c, s2_u, s2_e, s2_m} <= '0;
      else if (adv) begin
        s2_s <= s1_s;
        s2_c <= s1_c;
        s2_u <= s1_u;
        s2_e <= s1_e + 10'(sum[OUT_MAN_W]);
        s2_m <= sum[OUT_MAN_W-1:0];
      end
    assign ovf = s2_c == 2'd0 && s2_e >= EMAX;
    assign unf = s2_u || (s2_c == 2'd0 && s2_e <= 0);
    assign pk = s2_c == 2'd3 ? {s2_s, {OUT_EXP_W{1'b1}}, QM} :
                (s2_c == 2'd2 || ovf) ? {s2_s, {OUT_EXP_W{1'b1}}, {OUT_MAN_W{1'b0}}} :
                (s2_c == 2'd1 || unf) ? {s2_s, {(OW-1){1'b0}}} :
                {s2_s, s2_e[OUT_EXP_W-1:0], s2_m};
    // S3: register packed word and flags
    always_ff @(posedge clk)
      if (rst) {od, ov, un} <= '0;
      else if (adv) {od, ov, un} <= {pk, ovf, unf};
    assign m_data[OW*w +: OW] = od;
    assign m_ovf[w] = ov;
    assign m_unf[w] = un;
  end
endmodule

// File: tb/tb_float32_to_fltn_cplx_pipe.sv
// tb_float32_to_fltn_cplx_pipe: table vectors, corner sequences and randomized scoreboard checks for two converter configurations
module tb_float32_to_fltn_cplx_pipe;
  localparam int NA = 4;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic a_sv, a_sr, a_mv, a_mr;
  logic [255:0] a_sd;
  logic [143:0] a_md;
  logic [7:0] a_mo, a_mu;
  logic b_sv, b_sr, b_mv, b_mr;
  logic [63:0] b_sd;
  logic [31:0] b_md;
  logic [1:0] b_mo, b_mu;

  float32_to_fltn_cplx_pipe #(.NUM_LANES(NA), .OUT_EXP_W(8), .OUT_MAN_W(9)) dut_a (
    .clk(clk), .rst(rst), .s_valid(a_sv), .s_ready(a_sr), .s_data(a_sd),
    .m_valid(a_mv), .m_ready(a_mr), .m_data(a_md), .m_ovf(a_mo), .m_unf(a_mu));
  float32_to_fltn_cplx_pipe #(.NUM_LANES(1), .OUT_EXP_W(5), .OUT_MAN_W(10)) dut_b (
    .clk(clk), .rst(rst), .s_valid(b_sv), .s_ready(b_sr), .s_data(b_sd),
    .m_valid(b_mv), .m_ready(b_mr), .m_data(b_md), .m_ovf(b_mo), .m_unf(b_mu));

  typedef struct {logic [31:0] x; logic [17:0] y; logic o; logic u;} vec_t;
  typedef struct {logic [143:0] d; logic [7:0] o; logic [7:0] u;} exp_t;
  exp_t qa[$], qb[$];
  int checks = 0, errors = 0, rcv_a = 0;
  logic hold;
  logic [143:0] hold_d;
  logic [7:0] hold_o, hold_u;

  task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  // reference conversion from the format rules: integer significand, divide, round, renormalise
  function automatic void model(input logic [31:0] x, input int ew, input int mw,
                                output logic [31:0] y, output logic o, output logic u);
    int e, emax;
    longint q;
    emax = (1 << ew) - 1;
    o = 1'b0;
    u = 1'b0;
    y = 32'(x[31]) << (ew + mw);
    if (x[30:23] == 8'hFF) y |= (32'(emax) << mw) | (x[22:0] != 0 ? 32'(1) << (mw - 1) : 32'd0);
    else if (x[30:23] == 8'h00) u = x[22:0] != 0;
    else begin
      e = int'(x[30:23]) - 127 + (1 << (ew - 1)) - 1;
      q = longint'({1'b1, x[22:0]}) >> (23 - mw);
`ifdef FLT_RNE_EN
      begin
        longint r, h;
        r = longint'({1'b1, x[22:0]}) - (q << (23 - mw));
        h = longint'(1) << (22 - mw);
        if (r > h || (r == h && q[0])) q++;
      end
`endif
      if (q == (longint'(1) << (mw + 1))) begin q = q >> 1; e++; end
      if (e >= emax) begin y |= 32'(emax) << mw; o = 1'b1; end
      else if (e <= 0) u = 1'b1;
      else y |= (32'(e) << mw) | 32'(q - (longint'(1) << mw));
    end
  endfunction

  function automatic exp_t expect_beat(input logic [255:0] sd, input int nl, input int ew, input int mw);
    exp_t e;
    logic [31:0] y;
    logic o, u;
    e.d = '0; e.o = '0; e.u = '0;
    for (int w = 0; w < 2*nl; w++) begin
      model(sd[32*w +: 32], ew, mw, y, o, u);
      e.d |= 144'(y) << ((1 + ew + mw) * w);
      e.o[w] = o;
      e.u[w] = u;
    end
    return e;
  endfunction

  function automatic logic [31:0] rw();
    logic [31:0] x;
    x = $urandom;
    case ($urandom_range(0, 4))
      1: x[30:23] = 8'($urandom_range(95, 145));
      2: x[30:23] = $urandom_range(0, 1) ? 8'h00 : 8'hFF;
      3: x[30:23] = $urandom_range(0, 1) ? 8'hFE : 8'h01;
      4: x[22:0] = x[22:0] | 23'h7FFF;
      default: ;
    endcase
    return x;
  endfunction

  // one clock: score handshakes that fire at the coming edge, then step past it
  task automatic tick(output bit acc);
    exp_t e;
    #1;
    acc = a_sv && a_sr;
    if (acc) qa.push_back(expect_beat(a_sd, NA, 8, 9));
    if (b_sv && b_sr) qb.push_back(expect_beat(256'(b_sd), 1, 5, 10));
    if (a_mv && a_mr) begin
      if (qa.size() == 0) begin checks++; errors++; $display("FAIL a_extra: got unexpected beat %h want none", a_md); end
      else begin
        e = qa.pop_front();
        chk("a_data", a_md, e.d);
        chk("a_ovf", 144'(a_mo), 144'(e.o));
        chk("a_unf", 144'(a_mu), 144'(e.u));
        rcv_a++;
      end
    end
    if (b_mv && b_mr) begin
      if (qb.size() == 0) begin checks++; errors++; $display("FAIL b_extra: got unexpected beat %h want none", b_md); end
      else begin
        e = qb.pop_front();
        chk("b_data", 144'(b_md), e.d);
        chk("b_ovf", 144'(b_mo), 144'(e.o[1:0]));
        chk("b_unf", 144'(b_mu), 144'(e.u[1:0]));
      end
    end
    hold = a_mv && !a_mr && !rst;
    hold_d = a_md; hold_o = a_mo; hold_u = a_mu;
    @(posedge clk);
    #1;
    if (hold) begin
      chk("hold_valid", 144'(a_mv), 144'(1));
      chk("hold_data", a_md, hold_d);
      chk("hold_flags", 144'({a_mo, a_mu}), 144'({hold_o, hold_u}));
    end
  endtask

  initial begin
    vec_t tv[10], tvb[4];
    bit acc;
    int sent, r0;
    tv[0] = '{32'h3F800000, 18'h0FE00, 1'b0, 1'b0};
    tv[1] = '{32'hC0200000, 18'h30080, 1'b0, 1'b0};
    tv[2] = '{32'h3F802000, 18'h0FE00, 1'b0, 1'b0};
`ifdef FLT_RNE_EN
    tv[3] = '{32'h3F806000, 18'h0FE02, 1'b0, 1'b0};
    tv[4] = '{32'h7F7FFFFF, 18'h1FE00, 1'b1, 1'b0};
`else
    tv[3] = '{32'h3F806000, 18'h0FE01, 1'b0, 1'b0};
    tv[4] = '{32'h7F7FFFFF, 18'h1FDFF, 1'b0, 1'b0};
`endif
    tv[5] = '{32'h7FC00001, 18'h1FF00, 1'b0, 1'b0};
    tv[6] = '{32'hFF800000, 18'h3FE00, 1'b0, 1'b0};
    tv[7] = '{32'h00000001, 18'h00000, 1'b0, 1'b1};
    tv[8] = '{32'h80000000, 18'h20000, 1'b0, 1'b0};
    tv[9] = '{32'h00800000, 18'h00200, 1'b0, 1'b0};
    tvb[0] = '{32'h47800000, 18'h07C00, 1'b1, 1'b0};
    tvb[1] = '{32'h33000000, 18'h00000, 1'b0, 1'b1};
    tvb[2] = '{32'h3F800000, 18'h03C00, 1'b0, 1'b0};
    tvb[3] = '{32'hC7800000, 18'h0FC00, 1'b1, 1'b0};
    a_sv = 0; a_sd = '0; a_mr = 1; b_sv = 0; b_sd = '0; b_mr = 1;
    repeat (3) tick(acc);
    chk("rst_mvalid", 144'(a_mv), 144'(0));
    chk("rst_mdata", a_md, 144'(0));
    chk("rst_flags", 144'({a_mo, a_mu}), 144'(0));
    rst = 0;
    tick(acc);
    chk("rst_sready", 144'(a_sr), 144'(1));
    // latency of a single beat with m_ready held high
    a_sv = 1; a_sd = {4{32'h3F800000, 32'hC0200000}};
    tick(acc);
    chk("lat_accept", 144'(acc), 144'(1));
    a_sv = 0;
    tick(acc);
    chk("lat_early", 144'(a_mv), 144'(0));
    tick(acc);
    chk("lat_valid", 144'(a_mv), 144'(1));
    chk("lat_data", a_md, {4{18'h0FE00, 18'h30080}});
    chk("lat_flags", 144'({a_mo, a_mu}), 144'(0));
    tick(acc);
    // directed vectors, 18-bit format
    for (int i = 0; i < 10; i++) begin
      a_sv = 1; a_sd = {8{tv[i].x}};
      tick(acc);
      a_sv = 0;
      for (int n = 0; n < 8 && !a_mv; n++) tick(acc);
      chk($sformatf("tv%0d_valid", i), 144'(a_mv), 144'(1));
      chk($sformatf("tv%0d_data", i), a_md, {8{tv[i].y}});
      chk($sformatf("tv%0d_ovf", i), 144'(a_mo), 144'({8{tv[i].o}}));
      chk($sformatf("tv%0d_unf", i), 144'(a_mu), 144'({8{tv[i].u}}));
    end
    tick(acc);
    // directed vectors, half format
    for (int i = 0; i < 4; i++) begin
      b_sv = 1; b_sd = {2{tvb[i].x}};
      tick(acc);
      b_sv = 0;
      for (int n = 0; n < 8 && !b_mv; n++) tick(acc);
      chk($sformatf("tvb%0d_valid", i), 144'(b_mv), 144'(1));
      chk($sformatf("tvb%0d_data", i), 144'(b_md), 144'({2{tvb[i].y[15:0]}}));
      chk($sformatf("tvb%0d_flags", i), 144'({b_mo, b_mu}), 144'({{2{tvb[i].o}}, {2{tvb[i].u}}}));
    end
    tick(acc);
    // backpressure: 20 counting beats, m_ready low for 5 cycles mid-stream
    sent = 0; r0 = rcv_a;
    for (int c = 0; c < 80 && rcv_a - r0 < 20; c++) begin
      if (!a_mr && a_mv) chk("bp_sready", 144'(a_sr), 144'(0));
      a_sv = sent < 20;
      for (int w = 0; w < 8; w++) a_sd[32*w +: 32] = 32'h3F800000 + 32'((sent*8 + w) << 12);
      a_mr = !(c >= 8 && c < 13);
      tick(acc);
      if (acc) sent++;
    end
    a_sv = 0; a_mr = 1;
    chk("bp_count", 144'(rcv_a - r0), 144'(20));
    // reset with beats in flight: nothing left in flight may surface afterwards
    for (int i = 0; i < 3; i++) begin
      a_sv = 1;
      for (int w = 0; w < 8; w++) a_sd[32*w +: 32] = rw();
      tick(acc);
    end
    a_sv = 0; rst = 1;
    tick(acc);
    chk("mrst_mvalid", 144'(a_mv), 144'(0));
    chk("mrst_mdata", a_md, 144'(0));
    qa.delete();
    rst = 0;
    tick(acc);
    chk("mrst_sready", 144'(a_sr), 144'(1));
    repeat (4) tick(acc);
    // randomized traffic with random backpressure on both instances
    for (int c = 0; c < 400; c++) begin
      a_sv = $urandom_range(0, 3) != 0;
      for (int w = 0; w < 8; w++) a_sd[32*w +: 32] = rw();
      a_mr = $urandom_range(0, 3) != 0;
      b_sv = $urandom_range(0, 3) != 0;
      b_sd = {rw(), rw()};
      b_mr = $urandom_range(0, 3) != 0;
      tick(acc);
    end
    a_sv = 0; b_sv = 0; a_mr = 1; b_mr = 1;
    repeat (8) tick(acc);
    chk("a_drain", 144'(qa.size()), 144'(0));
    chk("b_drain", 144'(qb.size()), 144'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
